// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main controller.
// Registered control strobes; branch PC write qualified by live zero flag.
module multicycle_ctrl #(
    parameter int MEM_WAIT = 3,
    parameter bit EXC_EN   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       zero,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_wr,
    output logic       alu_out_w,
    output logic       epc_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       mux_addr,
    output logic [1:0] pc_src,
    output logic       rst_out,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_IRLOAD = 4'd2,
        S_DECODE = 4'd3,
        S_EXEC_R = 4'd4,
        S_EXEC_I = 4'd5,
        S_MADDR  = 4'd6,
        S_MEM_RD = 4'd7,
        S_MEM_WR = 4'd8,
        S_WB     = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_EXC    = 4'd12
    } state_t;

    localparam logic [3:0] WAIT    = 4'(MEM_WAIT);
    localparam logic [3:0] WAIT_M1 = 4'(MEM_WAIT - 1);

    state_t     st, st_n;
    logic [3:0] cnt, cnt_n;

    // Instruction class captured at DECODE, used by later states
    logic       is_r, is_r_n;
    logic       is_lw, is_lw_n;
    logic       is_beq, is_beq_n;
    logic       is_jal, is_jal_n;
    logic       ovf_chk, ovf_chk_n;
    logic [2:0] fn, fn_n;

    // Decoded view of the current IR fields
    logic       d_r, d_i, d_mem, d_br, d_j, d_ovf;
    logic [2:0] d_fn;

    logic       pcw_q, pcw_n;
    logic       irw_n, rw_n, mw_n, aow_n, epc_n, ma_n, rst_n_o;
    logic [1:0] sa_n, sb_n, rd_n, m2r_n, ps_n;
    logic [2:0] op_n;

    assign state = st;

    // Conditional PC write in BRANCH follows the ALU zero flag of this cycle
    assign pc_write = pcw_q
                    | ((st == S_BRANCH) & (is_beq ? zero : ~zero));

    // Classify opcode/funct into instruction groups
    always_comb begin
        d_r   = 1'b0;
        d_i   = 1'b0;
        d_mem = 1'b0;
        d_br  = 1'b0;
        d_j   = 1'b0;
        d_ovf = 1'b0;
        d_fn  = 3'b001;
        case (opcode)
            6'd0: begin
                case (funct)
                    6'd32: begin d_r = 1'b1; d_fn = 3'b001; d_ovf = 1'b1; end
                    6'd34: begin d_r = 1'b1; d_fn = 3'b010; d_ovf = 1'b1; end
                    6'd36: begin d_r = 1'b1; d_fn = 3'b011; end
                    6'd42: begin d_r = 1'b1; d_fn = 3'b111; end
                    default: ;
                endcase
            end
            6'd8:  begin d_i = 1'b1; d_ovf = 1'b1; end
            6'd10: begin d_i = 1'b1; d_fn = 3'b111; end
            6'd35, 6'd43: d_mem = 1'b1;
            6'd4,  6'd5:  d_br  = 1'b1;
            6'd2,  6'd3:  d_j   = 1'b1;
            default: ;
        endcase
    end

    // Next state, wait counter and captured instruction class
    always_comb begin
        st_n      = st;
        cnt_n     = cnt + 4'd1;
        is_r_n    = is_r;
        is_lw_n   = is_lw;
        is_beq_n  = is_beq;
        is_jal_n  = is_jal;
        ovf_chk_n = ovf_chk;
        fn_n      = fn;
        unique case (st)
            S_RST: begin
                if (cnt != 4'd0)
                    st_n = S_FETCH;
            end
            S_FETCH: begin
                if (cnt >= WAIT_M1)
                    st_n = S_IRLOAD;
            end
            S_IRLOAD: st_n = S_DECODE;
            S_DECODE: begin
                is_r_n    = d_r;
                is_lw_n   = (opcode == 6'd35);
                is_beq_n  = (opcode == 6'd4);
                is_jal_n  = (opcode == 6'd3);
                ovf_chk_n = d_ovf;
                fn_n      = d_fn;
                if (d_r)
                    st_n = S_EXEC_R;
                else if (d_i)
                    st_n = S_EXEC_I;
                else if (d_mem)
                    st_n = S_MADDR;
                else if (d_br)
                    st_n = S_BRANCH;
                else if (d_j)
                    st_n = S_JUMP;
                else
                    st_n = EXC_EN ? S_EXC : S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                if (EXC_EN && overflow && ovf_chk)
                    st_n = S_EXC;
                else
                    st_n = S_WB;
            end
            S_MADDR:  st_n = is_lw ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (cnt >= WAIT)
                    st_n = S_FETCH;
            end
            S_MEM_WR: begin
                if (cnt >= WAIT_M1)
                    st_n = S_FETCH;
            end
            S_WB, S_BRANCH, S_JUMP, S_EXC: st_n = S_FETCH;
            default: st_n = S_RST;
        endcase
        if (st_n != st)
            cnt_n = 4'd0;
    end

    // Control word for the state about to be entered
    always_comb begin
        pcw_n   = 1'b0;
        irw_n   = 1'b0;
        rw_n    = 1'b0;
        mw_n    = 1'b0;
        aow_n   = 1'b0;
        epc_n   = 1'b0;
        ma_n    = 1'b0;
        rst_n_o = 1'b0;
        sa_n    = 2'd0;
        sb_n    = 2'd0;
        rd_n    = 2'd0;
        m2r_n   = 2'd0;
        ps_n    = 2'd0;
        op_n    = 3'b000;
        unique case (st_n)
            S_RST: rst_n_o = 1'b1;
            S_FETCH: begin
                sb_n = 2'd1;
                op_n = 3'b001;
            end
            S_IRLOAD: begin
                irw_n = 1'b1;
                pcw_n = 1'b1;
                sb_n  = 2'd1;
                op_n  = 3'b001;
            end
            S_DECODE: begin
                sb_n  = 2'd3;
                op_n  = 3'b001;
                aow_n = 1'b1;
            end
            S_EXEC_R: begin
                sa_n  = 2'd1;
                op_n  = fn_n;
                aow_n = 1'b1;
            end
            S_EXEC_I, S_MADDR: begin
                sa_n  = 2'd1;
                sb_n  = 2'd2;
                op_n  = (st_n == S_MADDR) ? 3'b001 : fn_n;
                aow_n = 1'b1;
            end
            S_MEM_RD: begin
                if (cnt_n < WAIT) begin
                    ma_n = 1'b1;
                end else begin
                    rw_n  = 1'b1;
                    m2r_n = 2'd1;
                end
            end
            S_MEM_WR: begin
                if (cnt_n == 4'd0) begin
                    ma_n = 1'b1;
                    mw_n = 1'b1;
                end
            end
            S_WB: begin
                rw_n = 1'b1;
                rd_n = is_r_n ? 2'd1 : 2'd0;
            end
            S_BRANCH: begin
                sa_n = 2'd1;
                op_n = 3'b010;
                ps_n = 2'd1;
            end
            S_JUMP: begin
                pcw_n = 1'b1;
                ps_n  = 2'd2;
                if (is_jal_n) begin
                    rw_n = 1'b1;
                    rd_n = 2'd2;
                end
            end
            S_EXC: begin
                epc_n = 1'b1;
                pcw_n = 1'b1;
                ps_n  = 2'd3;
            end
            default: ;
        endcase
    end

    // State, counter and registered outputs; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= S_RST;
            cnt        <= 4'd0;
            is_r       <= 1'b0;
            is_lw      <= 1'b0;
            is_beq     <= 1'b0;
            is_jal     <= 1'b0;
            ovf_chk    <= 1'b0;
            fn         <= 3'b000;
            pcw_q      <= 1'b0;
            ir_write   <= 1'b0;
            reg_write  <= 1'b0;
            mem_wr     <= 1'b0;
            alu_out_w  <= 1'b0;
            epc_write  <= 1'b0;
            mux_addr   <= 1'b0;
            rst_out    <= 1'b1;
            alu_src_a  <= 2'd0;
            alu_src_b  <= 2'd0;
            alu_op     <= 3'b000;
            reg_dst    <= 2'd0;
            mem_to_reg <= 2'd0;
            pc_src     <= 2'd0;
        end else begin
            st         <= st_n;
            cnt        <= cnt_n;
            is_r       <= is_r_n;
            is_lw      <= is_lw_n;
            is_beq     <= is_beq_n;
            is_jal     <= is_jal_n;
            ovf_chk    <= ovf_chk_n;
            fn         <= fn_n;
            pcw_q      <= pcw_n;
            ir_write   <= irw_n;
            reg_write  <= rw_n;
            mem_wr     <= mw_n;
            alu_out_w  <= aow_n;
            epc_write  <= epc_n;
            mux_addr   <= ma_n;
            rst_out    <= rst_n_o;
            alu_src_a  <= sa_n;
            alu_src_b  <= sb_n;
            alu_op     <= op_n;
            reg_dst    <= rd_n;
            mem_to_reg <= m2r_n;
            pc_src     <= ps_n;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: three parameterisations driven by
// directed and random instruction streams against a trace model.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       rst, pcw, irw, rw, mw, aow, epc, ma;
        logic [1:0] sa, sb;
        logic [2:0] op;
        logic [1:0] rd, m2r, ps;
    } vec_t;

    logic       clk;
    logic       rst_i [3];
    logic [5:0] opc   [3];
    logic [5:0] fnc   [3];
    logic       ovf_i [3];
    logic       zr_i  [3];
    logic       pcw_o [3];
    logic       irw_o [3];
    logic       rw_o  [3];
    logic       mw_o  [3];
    logic       aow_o [3];
    logic       epc_o [3];
    logic [1:0] sa_o  [3];
    logic [1:0] sb_o  [3];
    logic [2:0] op_o  [3];
    logic [1:0] rd_o  [3];
    logic [1:0] m2r_o [3];
    logic       ma_o  [3];
    logic [1:0] ps_o  [3];
    logic       ro_o  [3];
    logic [3:0] st_o  [3];

    int   total = 0;
    int   bad   = 0;
    vec_t q[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        multicycle_ctrl #(
            .MEM_WAIT(g == 0 ? 3 : (g == 1 ? 5 : 1)),
            .EXC_EN  (g == 2 ? 1'b0 : 1'b1)
        ) dut (
            .clk       (clk),
            .reset     (rst_i[g]),
            .opcode    (opc[g]),
            .funct     (fnc[g]),
            .overflow  (ovf_i[g]),
            .zero      (zr_i[g]),
            .pc_write  (pcw_o[g]),
            .ir_write  (irw_o[g]),
            .reg_write (rw_o[g]),
            .mem_wr    (mw_o[g]),
            .alu_out_w (aow_o[g]),
            .epc_write (epc_o[g]),
            .alu_src_a (sa_o[g]),
            .alu_src_b (sb_o[g]),
            .alu_op    (op_o[g]),
            .reg_dst   (rd_o[g]),
            .mem_to_reg(m2r_o[g]),
            .mux_addr  (ma_o[g]),
            .pc_src    (ps_o[g]),
            .rst_out   (ro_o[g]),
            .state     (st_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mw_of(input int k);
        return (k == 0) ? 3 : ((k == 1) ? 5 : 1);
    endfunction

    function automatic bit en_of(input int k);
        return k != 2;
    endfunction

    function automatic vec_t mk(input logic [3:0] s);
        vec_t v;
        v    = '0;
        v.st = s;
        return v;
    endfunction

    function automatic vec_t obs(input int k);
        vec_t v;
        v.st  = st_o[k];
        v.rst = ro_o[k];
        v.pcw = pcw_o[k];
        v.irw = irw_o[k];
        v.rw  = rw_o[k];
        v.mw  = mw_o[k];
        v.aow = aow_o[k];
        v.epc = epc_o[k];
        v.ma  = ma_o[k];
        v.sa  = sa_o[k];
        v.sb  = sb_o[k];
        v.op  = op_o[k];
        v.rd  = rd_o[k];
        v.m2r = m2r_o[k];
        v.ps  = ps_o[k];
        return v;
    endfunction

    task automatic chk(input string tag, input vec_t got, input vec_t exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_exc();
        vec_t v;
        v = mk(12); v.epc = 1; v.pcw = 1; v.ps = 3;
        q.push_back(v);
    endtask

    // Expected per-cycle trace of one instruction, from FETCH onwards
    task automatic build(input int mw, input bit en, input logic [5:0] op,
                         input logic [5:0] fn, input bit ovf, input bit z);
        vec_t v;
        logic [2:0] f;
        q.delete();
        v = mk(1); v.sb = 1; v.op = 1;
        repeat (mw) q.push_back(v);
        v = mk(2); v.irw = 1; v.pcw = 1; v.sb = 1; v.op = 1;
        q.push_back(v);
        v = mk(3); v.sb = 3; v.op = 1; v.aow = 1;
        q.push_back(v);
        f = (fn == 32) ? 3'd1 : (fn == 34) ? 3'd2 :
            (fn == 36) ? 3'd3 : (fn == 42) ? 3'd7 : 3'd0;
        if (op == 0 && f != 0) begin
            v = mk(4); v.sa = 1; v.op = f; v.aow = 1;
            q.push_back(v);
            if (en && ovf && (fn == 32 || fn == 34)) push_exc();
            else begin
                v = mk(9); v.rw = 1; v.rd = 1; q.push_back(v);
            end
        end else if (op == 8 || op == 10) begin
            v = mk(5); v.sa = 1; v.sb = 2; v.aow = 1;
            v.op = (op == 8) ? 3'd1 : 3'd7;
            q.push_back(v);
            if (en && ovf && op == 8) push_exc();
            else begin
                v = mk(9); v.rw = 1; q.push_back(v);
            end
        end else if (op == 35 || op == 43) begin
            v = mk(6); v.sa = 1; v.sb = 2; v.op = 1; v.aow = 1;
            q.push_back(v);
            if (op == 35) begin
                v = mk(7); v.ma = 1;
                repeat (mw) q.push_back(v);
                v = mk(7); v.rw = 1; v.m2r = 1;
                q.push_back(v);
            end else begin
                v = mk(8); v.ma = 1; v.mw = 1;
                q.push_back(v);
                v = mk(8);
                repeat (mw - 1) q.push_back(v);
            end
        end else if (op == 4 || op == 5) begin
            v = mk(10); v.sa = 1; v.op = 2; v.ps = 1;
            v.pcw = (op == 4) ? z : !z;
            q.push_back(v);
        end else if (op == 2 || op == 3) begin
            v = mk(11); v.pcw = 1; v.ps = 2;
            if (op == 3) begin v.rw = 1; v.rd = 2; end
            q.push_back(v);
        end else if (en) begin
            push_exc();
        end
    endtask

    task automatic do_reset(input int k);
        vec_t v;
        v = mk(0); v.rst = 1;
        rst_i[k] = 1'b1;
        @(posedge clk); #1 chk($sformatf("u%0d_rst1", k), obs(k), v);
        @(posedge clk); #1 chk($sformatf("u%0d_rst2", k), obs(k), v);
        rst_i[k] = 1'b0;
        @(posedge clk); #1 chk($sformatf("u%0d_rst3", k), obs(k), v);
    endtask

    task automatic run(input int k, input logic [5:0] op, input logic [5:0] fn,
                       input bit ovf, input bit z, input bit abort_wr);
        build(mw_of(k), en_of(k), op, fn, ovf, z);
        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk);
            #1 chk($sformatf("u%0d_op%0d_fn%0d_c%0d", k, op, fn, i), obs(k), q[i]);
            if (i == 0) begin
                opc[k]   = op;
                fnc[k]   = fn;
                ovf_i[k] = ovf;
                zr_i[k]  = z;
            end
            if (abort_wr && q[i].mw) begin
                do_reset(k);
                return;
            end
        end
    endtask

    task automatic rand_run(input int k, input int n);
        logic [11:0] tbl [15];
        int j;
        tbl = '{{6'd0, 6'd32}, {6'd0, 6'd34}, {6'd0, 6'd36}, {6'd0, 6'd42},
                {6'd0, 6'd7},  {6'd8, 6'd0},  {6'd10, 6'd0}, {6'd35, 6'd0},
                {6'd43, 6'd0}, {6'd4, 6'd0},  {6'd5, 6'd0},  {6'd2, 6'd0},
                {6'd3, 6'd0},  {6'd63, 6'd0}, {6'd12, 6'd32}};
        for (int i = 0; i < n; i++) begin
            j = int'($urandom_range(0, 14));
            run(k, tbl[j][11:6], tbl[j][5:0],
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_i[k] = 1'b0;
            opc[k]   = 6'd0;
            fnc[k]   = 6'd0;
            ovf_i[k] = 1'b0;
            zr_i[k]  = 1'b0;
        end
        @(posedge clk);
        #1;

        do_reset(0);
        run(0, 6'd0,  6'd32, 1'b0, 1'b0, 1'b0);
        run(0, 6'd8,  6'd0,  1'b1, 1'b0, 1'b0);
        run(0, 6'd4,  6'd0,  1'b0, 1'b0, 1'b0);
        run(0, 6'd4,  6'd0,  1'b0, 1'b1, 1'b0);
        run(0, 6'd5,  6'd0,  1'b0, 1'b0, 1'b0);
        run(0, 6'd5,  6'd0,  1'b0, 1'b1, 1'b0);
        run(0, 6'd63, 6'd0,  1'b0, 1'b0, 1'b0);
        run(0, 6'd0,  6'd34, 1'b1, 1'b0, 1'b0);
        run(0, 6'd3,  6'd0,  1'b0, 1'b0, 1'b0);
        run(0, 6'd43, 6'd0,  1'b0, 1'b0, 1'b1);
        rand_run(0, 30);

        do_reset(1);
        run(1, 6'd35, 6'd0,  1'b0, 1'b0, 1'b0);
        run(1, 6'd43, 6'd0,  1'b0, 1'b0, 1'b0);
        run(1, 6'd10, 6'd0,  1'b1, 1'b0, 1'b0);
        rand_run(1, 30);

        do_reset(2);
        run(2, 6'd63, 6'd0,  1'b0, 1'b0, 1'b0);
        run(2, 6'd8,  6'd0,  1'b1, 1'b0, 1'b0);
        run(2, 6'd35, 6'd0,  1'b0, 1'b0, 1'b0);
        run(2, 6'd43, 6'd0,  1'b0, 1'b0, 1'b0);
        run(2, 6'd43, 6'd0,  1'b0, 1'b0, 1'b1);
        rand_run(2, 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
